fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the OTTER pipeline: owns the PC register, issues reads to the synchronous instruction memory, and loads the IF/ID register that feeds decode. Directly consumes the `reg_en` / `pc_write` stall outputs of the data-hazard unit and the taken-branch/jump redirect from execute. A one-entry skid buffer keeps a returning instruction from being lost while decode is stalled.

## Interface

Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.
- `NOP_INSTR`, default `32'h0000_0013` (`addi x0,x0,0`): bubble written into IF/ID.

Ports:
- `clk` input 1: the single clock; all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `pc_write` input 1: from hazard unit; 0 freezes PC, no new fetch.
- `reg_en` input 1: from hazard unit; 0 holds IF/ID.
- `redirect_valid` input 1: taken branch/jump in execute; flushes fetch.
- `redirect_pc` input 32: redirect target; bits [1:0] ignored (treated as 0).
- `imem_addr` output 32: read address, equals PC register.
- `imem_rd_en` output 1: read strobe.
- `imem_rdata` input 32: read data, valid exactly one cycle after `imem_rd_en`, not held afterwards.
- `ifid_ir` output 32: instruction to decode.
- `ifid_pc` output 32: PC of `ifid_ir`.
- `ifid_valid` output 1: `ifid_ir` is a real instruction (0 = bubble).

## Operation

- State: `pc_q`, `req_valid_q` / `req_pc_q` (request in flight), `skid_valid_q` / `skid_ir_q` / `skid_pc_q`, plus the IF/ID registers.
- `issue = !redirect_valid && pc_write && reg_en`. Drive `imem_rd_en = issue`. On issue: `req_valid_q <= 1`, `req_pc_q <= pc_q`, `pc_q <= pc_q + 4`, modulo 2^32, so `FFFF_FFFC` wraps to 0. Otherwise `req_valid_q <= 0`.
- Response this cycle: `resp = req_valid_q`, carrying `{imem_rdata, req_pc_q}`.
- Source priority for IF/ID: skid entry, then response, then none.
- Flush (`redirect_valid`=1) has the highest priority and overrides stall:
  - `pc_q <= {redirect_pc[31:2],2'b00}`.
  - In-flight response and skid discarded.
  - `ifid_valid <= 0`, `ifid_ir <= NOP_INSTR`, `ifid_pc <= 0`.
- Else if `reg_en`=1:
  - IF/ID loads the source and the skid clears.
  - With no source, IF/ID loads a bubble: `ifid_valid`=0, `ifid_ir`=NOP.
- Else (`reg_en`=0):
  - IF/ID holds.
  - If `resp`, the response goes to skid: `skid_valid_q <= 1`.
- Invariant: a response never arrives while the skid is full, because a response implies `reg_en` was 1 in the previous cycle, which drained the skid. The bench asserts this.
- `pc_write`=1 with `reg_en`=0 does not fetch (issue requires both).
- `pc_write`=0 with `reg_en`=1 drains the existing source into IF/ID with no new fetch.

## Timing

- Reset values: `pc_q`=`RESET_PC`, `imem_addr`=`RESET_PC`, `imem_rd_en`=1 once `rst_n` high and inputs allow issue, all valid bits 0, `ifid_ir`=`NOP_INSTR`, `ifid_pc`=0, skid/req regs 0.
- Latency: issue of PC X in cycle n, `imem_rdata` in n+1, `ifid_ir`=instr(X) with `ifid_valid`=1 in n+2.
- Steady-state throughput is 1 instruction/cycle.
- Stall release: the instruction held in skid appears in IF/ID in the first cycle after `reg_en` returns to 1. A new issue occurs that same cycle, so there is no bubble.
- Redirect in cycle n: target issued in n+1, reaches IF/ID in n+3; IF/ID shows a bubble in n+1 and n+2.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). In-flight data is dropped.

## Structure

- Package `otter_pipe_pkg`:
  - `NOP_INSTR` and `RESET_PC` defaults.
  - Opcode constants shared with the hazard unit (`OP_BRANCH=7'b1100011`, `OP_STORE=7'b0100011`, `OP_RTYPE=7'b0110011`).
  - `fetch_pkt_t` struct `{logic [31:0] ir; logic [31:0] pc;}`.
- Sub-module `fetch_skid_buffer`: one-entry `fetch_pkt_t` holding register with load/drain/flush. Top level holds PC, request tracking, and IF/ID.

## Test plan

1. Reset release with all enables high, memory returns `mem[a]=a^32'hA5A5_0000` → `ifid_pc` sequence 0,4,8,… starting 2 cycles after the first issue, `ifid_valid`=1 every cycle.
2. Drop `reg_en`/`pc_write` for 3 cycles while PC 0x8 is in flight → 0x8 held in skid, IF/ID holds 0x4, `imem_rd_en`=0. After release: 0x8 then 0xC on consecutive cycles with no gap or duplicate.
3. `redirect_valid` with `redirect_pc=0x100` while streaming → two bubbles (`ifid_valid`=0, `ifid_ir`=0x13), then `ifid_pc`=0x100, 0x104.
4. Redirect asserted during a stall with a full skid (`reg_en`=0) → flush wins, skid cleared, `ifid_pc`=0x100 three cycles later.
5. `RESET_PC=32'hFFFF_FFF8`, stream → `ifid_pc` FFFF_FFF8, FFFF_FFFC, 0000_0000. Also `redirect_pc=0x103` → fetch at 0x100.
6. Assert `rst_n`=0 mid-stall with the skid full → outputs return to reset values without a clock edge, and the first post-reset instruction comes from `RESET_PC`.

Source files
------------

// File: rtl/otter_pipe_pkg.sv
// Shared definitions for the OTTER pipeline front end.
//   - Default reset PC and NOP bubble encoding used by fetch.
//   - Opcode constants shared with the data-hazard unit.
//   - fetch_pkt_t: instruction word paired with the PC it was fetched from.
//   - align_word(): forces a byte address onto a 4-byte boundary.
package otter_pipe_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } fetch_pkt_t;

  // Low two address bits are ignored by clearing them.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an instruction returning from memory while
// decode is stalled.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_load      : capture i_pkt (a response arriving during a stall)
//   i_drain     : entry has been consumed by IF/ID this cycle
//   i_flush     : discard the entry (redirect); wins over load/drain
//   i_pkt       : incoming instruction/PC pair
//   o_valid     : entry holds a pending instruction
//   o_pkt       : held instruction/PC pair
module fetch_skid_buffer
  import otter_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_drain,
  input  logic       i_flush,
  input  fetch_pkt_t i_pkt,
  output logic       o_valid,
  output fetch_pkt_t o_pkt
);

  logic       r_valid;
  fetch_pkt_t r_pkt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pkt   <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_pkt   <= '0;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pkt   <= i_pkt;
    end
  end

  assign o_valid = r_valid;
  assign o_pkt   = r_pkt;

endmodule

// File: rtl/fetch_stage.sv
// OTTER instruction-fetch stage: PC register, synchronous instruction-memory
// request tracking, skid buffer for stalls, and the IF/ID register.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   pc_write        : 0 freezes the PC (no new fetch)
//   reg_en          : 0 holds IF/ID
//   redirect_valid  : taken branch/jump, flushes fetch (overrides stall)
//   redirect_pc     : redirect target, low two bits ignored
//   imem_addr       : instruction-memory read address (the PC register)
//   imem_rd_en      : read strobe
//   imem_rdata      : read data, valid one cycle after imem_rd_en only
//   ifid_ir/ifid_pc : instruction and its PC for decode
//   ifid_valid      : 1 = real instruction, 0 = bubble
module fetch_stage
  import otter_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        reg_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_ir,
  output logic [31:0] ifid_pc,
  output logic        ifid_valid
);

  logic [31:0] r_pc;
  logic        r_req_valid;
  logic [31:0] r_req_pc;
  logic        r_ifid_valid;
  logic [31:0] r_ifid_ir;
  logic [31:0] r_ifid_pc;

  logic       w_issue;
  logic       w_resp;
  fetch_pkt_t w_resp_pkt;
  logic       w_skid_valid;
  fetch_pkt_t w_skid_pkt;
  logic       w_skid_load;
  logic       w_skid_drain;
  logic       w_src_valid;
  fetch_pkt_t w_src_pkt;

  // A fetch needs both hazard enables: issuing while IF/ID is frozen would
  // produce a second response with nowhere to go once the skid is full.
  assign w_issue = !redirect_valid && pc_write && reg_en;

  // The memory answers exactly one cycle after the request.
  assign w_resp        = r_req_valid;
  assign w_resp_pkt.ir = imem_rdata;
  assign w_resp_pkt.pc = r_req_pc;

  assign w_skid_load  = !redirect_valid && !reg_en && w_resp;
  assign w_skid_drain = !redirect_valid && reg_en;

  fetch_skid_buffer u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_flush (redirect_valid),
    .i_pkt   (w_resp_pkt),
    .o_valid (w_skid_valid),
    .o_pkt   (w_skid_pkt)
  );

  // The skid entry is older than any live response, so it goes first.
  always_comb begin
    w_src_valid = w_skid_valid || w_resp;
    w_src_pkt   = w_skid_valid ? w_skid_pkt : w_resp_pkt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= align_word(redirect_pc);
    end else if (w_issue) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_valid <= 1'b0;
      r_req_pc    <= '0;
    end else begin
      r_req_valid <= w_issue;
      if (w_issue) begin
        r_req_pc <= r_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifid_valid <= 1'b0;
      r_ifid_ir    <= NOP_INSTR;
      r_ifid_pc    <= '0;
    end else if (redirect_valid) begin
      r_ifid_valid <= 1'b0;
      r_ifid_ir    <= NOP_INSTR;
      r_ifid_pc    <= '0;
    end else if (reg_en) begin
      r_ifid_valid <= w_src_valid;
      if (w_src_valid) begin
        r_ifid_ir <= w_src_pkt.ir;
        r_ifid_pc <= w_src_pkt.pc;
      end else begin
        r_ifid_ir <= NOP_INSTR;
        r_ifid_pc <= '0;
      end
    end
  end

  assign imem_addr  = r_pc;
  assign imem_rd_en = w_issue;
  assign ifid_ir    = r_ifid_ir;
  assign ifid_pc    = r_ifid_pc;
  assign ifid_valid = r_ifid_valid;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_write = 1'b1;
  logic        reg_en = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic [31:0] addr1, rdata1, ir1, pc1;
  logic        rd1, v1;
  logic [31:0] addr2, rdata2, ir2, pc2;
  logic        rd2, v2;

  int total = 0;
  int bad = 0;

  localparam logic [31:0] MK = 32'hA5A5_0000;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .reg_en(reg_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(addr1), .imem_rd_en(rd1), .imem_rdata(rdata1),
    .ifid_ir(ir1), .ifid_pc(pc1), .ifid_valid(v1)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .reg_en(reg_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(addr2), .imem_rd_en(rd2), .imem_rdata(rdata2),
    .ifid_ir(ir2), .ifid_pc(pc2), .ifid_valid(v2)
  );

  // Synchronous instruction memories: data only in the cycle after a read.
  always @(posedge clk) begin
    rdata1 <= rd1 ? (addr1 ^ MK) : 32'hDEAD_BEEF;
    rdata2 <= rd2 ? (addr2 ^ MK) : 32'hDEAD_BEEF;
  end

  // A response must never land on a full skid entry.
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if (dut.r_req_valid && dut.w_skid_valid) begin
        bad++;
        $display("FAIL skid_invariant resp=%b skid=%b required no overlap", dut.r_req_valid, dut.w_skid_valid);
      end
    end
  end

  task automatic do_reset;
    rst_n = 1'b0; pc_write = 1'b1; reg_en = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (v1 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", v1); end
    total++; if (ir1 !== 32'h13) begin bad++; $display("FAIL reset_ir got=%h exp=00000013", ir1); end
    total++; if (pc1 !== 32'h0) begin bad++; $display("FAIL reset_ifid_pc got=%h exp=0", pc1); end
    total++; if (addr1 !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", addr1); end
    total++; if (addr2 !== 32'hFFFF_FFF8) begin bad++; $display("FAIL reset_addr2 got=%h exp=fffffff8", addr2); end
  endtask

  task automatic test_stream;
    logic [31:0] e;
    do_reset;
    total++; if (addr1 !== 32'h0) begin bad++; $display("FAIL stream_addr0 got=%h exp=0", addr1); end
    total++; if (rd1 !== 1'b1) begin bad++; $display("FAIL stream_rd_en got=%b exp=1", rd1); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total++; if (v1 !== 1'b0) begin bad++; $display("FAIL stream_first_bubble got=%b exp=0", v1); end
      end else begin
        e = 32'((k - 2) * 4);
        total++; if (v1 !== 1'b1) begin bad++; $display("FAIL stream_valid k=%0d got=%b exp=1", k, v1); end
        total++; if (pc1 !== e) begin bad++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, pc1, e); end
        total++; if (ir1 !== (e ^ MK)) begin bad++; $display("FAIL stream_ir k=%0d got=%h exp=%h", k, ir1, e ^ MK); end
      end
    end
  endtask

  task automatic test_stall;
    do_reset;
    repeat (3) @(negedge clk);
    total++; if (pc1 !== 32'h4) begin bad++; $display("FAIL stall_pre got=%h exp=00000004", pc1); end
    reg_en = 1'b0; pc_write = 1'b0;
    #1;
    total++; if (rd1 !== 1'b0) begin bad++; $display("FAIL stall_rd_en got=%b exp=0", rd1); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (pc1 !== 32'h4 || v1 !== 1'b1) begin bad++; $display("FAIL stall_hold k=%0d got=%h/%b exp=00000004/1", k, pc1, v1); end
      total++; if (rd1 !== 1'b0) begin bad++; $display("FAIL stall_rd_hold k=%0d got=%b exp=0", k, rd1); end
      total++; if (addr1 !== 32'hC) begin bad++; $display("FAIL stall_addr k=%0d got=%h exp=0000000c", k, addr1); end
    end
    reg_en = 1'b1; pc_write = 1'b1;
    #1;
    total++; if (rd1 !== 1'b1) begin bad++; $display("FAIL release_rd_en got=%b exp=1", rd1); end
    @(negedge clk);
    total++; if (pc1 !== 32'h8 || v1 !== 1'b1) begin bad++; $display("FAIL release_skid got=%h/%b exp=00000008/1", pc1, v1); end
    total++; if (ir1 !== (32'h8 ^ MK)) begin bad++; $display("FAIL release_skid_ir got=%h exp=%h", ir1, 32'h8 ^ MK); end
    @(negedge clk);
    total++; if (pc1 !== 32'hC || v1 !== 1'b1) begin bad++; $display("FAIL release_next got=%h/%b exp=0000000c/1", pc1, v1); end
    total++; if (ir1 !== (32'hC ^ MK)) begin bad++; $display("FAIL release_next_ir got=%h exp=%h", ir1, 32'hC ^ MK); end
    @(negedge clk);
    total++; if (pc1 !== 32'h10) begin bad++; $display("FAIL release_third got=%h exp=00000010", pc1); end
  endtask

  task automatic test_redirect;
    do_reset;
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    total++; if (rd1 !== 1'b0) begin bad++; $display("FAIL redir_rd_en got=%b exp=0", rd1); end
    @(negedge clk);
    total++; if (v1 !== 1'b0 || ir1 !== 32'h13 || pc1 !== 32'h0) begin bad++; $display("FAIL redir_bubble1 got=%b/%h/%h exp=0/00000013/0", v1, ir1, pc1); end
    total++; if (addr1 !== 32'h100) begin bad++; $display("FAIL redir_addr got=%h exp=00000100", addr1); end
    redirect_valid = 1'b0;
    @(negedge clk);
    total++; if (v1 !== 1'b0 || ir1 !== 32'h13) begin bad++; $display("FAIL redir_bubble2 got=%b/%h exp=0/00000013", v1, ir1); end
    @(negedge clk);
    total++; if (pc1 !== 32'h100 || v1 !== 1'b1 || ir1 !== (32'h100 ^ MK)) begin bad++; $display("FAIL redir_target got=%h/%b/%h exp=00000100/1/%h", pc1, v1, ir1, 32'h100 ^ MK); end
    @(negedge clk);
    total++; if (pc1 !== 32'h104 || v1 !== 1'b1) begin bad++; $display("FAIL redir_next got=%h/%b exp=00000104/1", pc1, v1); end
  endtask

  task automatic test_redirect_stall;
    do_reset;
    repeat (3) @(negedge clk);
    reg_en = 1'b0; pc_write = 1'b0;
    @(negedge clk);
    total++; if (pc1 !== 32'h4) begin bad++; $display("FAIL rstall_hold got=%h exp=00000004", pc1); end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    total++; if (v1 !== 1'b0 || ir1 !== 32'h13) begin bad++; $display("FAIL rstall_flush got=%b/%h exp=0/00000013", v1, ir1); end
    total++; if (addr1 !== 32'h100) begin bad++; $display("FAIL rstall_addr got=%h exp=00000100", addr1); end
    redirect_valid = 1'b0; reg_en = 1'b1; pc_write = 1'b1;
    @(negedge clk);
    total++; if (v1 !== 1'b0) begin bad++; $display("FAIL rstall_skid_cleared got=%b/%h exp=0", v1, pc1); end
    @(negedge clk);
    total++; if (pc1 !== 32'h100 || v1 !== 1'b1) begin bad++; $display("FAIL rstall_target got=%h/%b exp=00000100/1", pc1, v1); end
  endtask

  task automatic test_wrap;
    do_reset;
    total++; if (addr2 !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_addr0 got=%h exp=fffffff8", addr2); end
    repeat (2) @(negedge clk);
    total++; if (pc2 !== 32'hFFFF_FFF8 || ir2 !== 32'h5A5A_FFF8) begin bad++; $display("FAIL wrap_pc0 got=%h/%h exp=fffffff8/5a5afff8", pc2, ir2); end
    @(negedge clk);
    total++; if (pc2 !== 32'hFFFF_FFFC || ir2 !== 32'h5A5A_FFFC) begin bad++; $display("FAIL wrap_pc1 got=%h/%h exp=fffffffc/5a5afffc", pc2, ir2); end
    @(negedge clk);
    total++; if (pc2 !== 32'h0 || v2 !== 1'b1 || ir2 !== MK) begin bad++; $display("FAIL wrap_pc2 got=%h/%b/%h exp=0/1/a5a50000", pc2, v2, ir2); end
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    @(negedge clk);
    total++; if (addr1 !== 32'h100) begin bad++; $display("FAIL align_addr got=%h exp=00000100", addr1); end
    total++; if (addr2 !== 32'h100) begin bad++; $display("FAIL align_addr2 got=%h exp=00000100", addr2); end
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (pc2 !== 32'h100 || v2 !== 1'b1) begin bad++; $display("FAIL align_target got=%h/%b exp=00000100/1", pc2, v2); end
  endtask

  task automatic test_async_reset;
    do_reset;
    repeat (3) @(negedge clk);
    reg_en = 1'b0; pc_write = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (v1 !== 1'b0 || ir1 !== 32'h13 || pc1 !== 32'h0) begin bad++; $display("FAIL areset_ifid got=%b/%h/%h exp=0/00000013/0", v1, ir1, pc1); end
    total++; if (addr1 !== 32'h0) begin bad++; $display("FAIL areset_addr got=%h exp=0", addr1); end
    total++; if (dut.w_skid_valid !== 1'b0) begin bad++; $display("FAIL areset_skid got=%b exp=0", dut.w_skid_valid); end
    reg_en = 1'b1; pc_write = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (rd1 !== 1'b1 || addr1 !== 32'h0) begin bad++; $display("FAIL areset_issue got=%b/%h exp=1/0", rd1, addr1); end
    @(negedge clk);
    total++; if (v1 !== 1'b0) begin bad++; $display("FAIL areset_bubble got=%b/%h exp=0", v1, pc1); end
    @(negedge clk);
    total++; if (pc1 !== 32'h0 || v1 !== 1'b1 || ir1 !== MK) begin bad++; $display("FAIL areset_first got=%h/%b/%h exp=0/1/a5a50000", pc1, v1, ir1); end
    @(negedge clk);
    total++; if (pc1 !== 32'h4 || v1 !== 1'b1) begin bad++; $display("FAIL areset_second got=%h/%b exp=00000004/1", pc1, v1); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_redirect;
    test_redirect_stall;
    test_wrap;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
